// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the conv sliding-window sequencer.
// Stride-2 window selection is enabled by defining CONV_SLIDE_STRIDE2_EN.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } conv_slide_state_t;

`ifdef CONV_SLIDE_STRIDE2_EN
    localparam int STRIDE = 2;
`else
    localparam int STRIDE = 1;
`endif

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Legal windows per frame for the given geometry and stride.
    function automatic int win_count(input int len, input int rows,
                                     input int k, input int stride);
        return ((len - k) / stride + 1) * ((rows - k) / stride + 1);
    endfunction

endpackage

// File: rtl/conv_slide_ctrl_if.sv
// Pixel-in / shifter / window-out bundle of the sliding-window sequencer.
// master: layer controller + upstream + downstream side; slave: sequencer.
interface conv_slide_ctrl_if #(
    parameter int DATA_WIDTH = 6,
    parameter int LEN        = 9,
    parameter int ROWS       = 9
);
    import conv_pkg::*;

    localparam int CW = cnt_w(LEN);
    localparam int RW = cnt_w(ROWS);

    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  shift_en;
    logic [DATA_WIDTH-1:0] shift_data;
    logic                  win_valid;
    logic [RW-1:0]         win_row;
    logic [CW-1:0]         win_col;
    logic                  ds_ready;
    logic                  busy;
    logic                  done;

    modport master (
        output start, in_valid, in_data, ds_ready,
        input  in_ready, shift_en, shift_data,
        input  win_valid, win_row, win_col, busy, done
    );

    modport slave (
        input  start, in_valid, in_data, ds_ready,
        output in_ready, shift_en, shift_data,
        output win_valid, win_row, win_col, busy, done
    );

endinterface

// File: rtl/conv_pos_cnt.sv
// Raster column/row position counter with clear, enable and end-of-frame flag.
// Ports: clk, rstn, clr, en in; col, row, eof out (eof at ROWS-1, LEN-1).
module conv_pos_cnt
    import conv_pkg::*;
#(
    parameter int LEN  = 9,
    parameter int ROWS = 9,
    parameter int CW   = cnt_w(LEN),
    parameter int RW   = cnt_w(ROWS)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          eof
);

    localparam logic [CW-1:0] COL_LAST = CW'(LEN - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    logic col_wrap;

    assign col_wrap = (col == COL_LAST);
    assign eof      = col_wrap && (row == ROW_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_wrap) begin
                col <= '0;
                row <= eof ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_slide_ctrl.sv
// Sequencer for the KxK line-buffer shifter: feeds pixels, flags legal windows.
// Ports: clk, rstn, bus (conv_slide_ctrl_if.slave). Macro: CONV_SLIDE_STRIDE2_EN.
module conv_slide_ctrl
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int K          = 3,
    parameter int LEN        = 9,
    parameter int ROWS       = 9
) (
    input  logic clk,
    input  logic rstn,
    conv_slide_ctrl_if.slave bus
);

    localparam int CW = cnt_w(LEN);
    localparam int RW = cnt_w(ROWS);

    localparam logic [CW-1:0] KC = CW'(K - 1);
    localparam logic [RW-1:0] KR = RW'(K - 1);

    conv_slide_state_t state, state_nxt;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          eof;
    logic          ready;
    logic          accept;
    logic          in_range;
    logic          stride_ok;
    logic          qualify;
    logic [CW-1:0] rel_col;
    logic [RW-1:0] rel_row;

    logic          win_valid_q;
    logic [RW-1:0] win_row_q;
    logic [CW-1:0] win_col_q;

    conv_pos_cnt #(
        .LEN  (LEN),
        .ROWS (ROWS),
        .CW   (CW),
        .RW   (RW)
    ) u_pos (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state == IDLE),
        .en   (accept),
        .col  (col),
        .row  (row),
        .eof  (eof)
    );

    assign accept   = bus.in_valid && ready;
    assign in_range = (row >= KR) && (col >= KC);

    // Only meaningful when in_range; the window register ignores it otherwise.
    assign rel_row  = row - KR;
    assign rel_col  = col - KC;

`ifdef CONV_SLIDE_STRIDE2_EN
    assign stride_ok = !rel_row[0] && !rel_col[0];
`else
    assign stride_ok = 1'b1;
`endif

    assign qualify = accept && in_range && stride_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = STREAM;
            STREAM:  if (accept && eof) state_nxt = DRAIN;
            DRAIN:   if (!win_valid_q || bus.ds_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A pending unconsumed window freezes the shifter.
    always_comb begin
        ready    = (state == STREAM) && !(win_valid_q && !bus.ds_ready);
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
    end

    // Window tracks the shifter one cycle behind the qualifying accept;
    // consume and new window in one cycle keeps full throughput.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else if (qualify) begin
            win_valid_q <= 1'b1;
            win_row_q   <= rel_row;
            win_col_q   <= rel_col;
        end else if (bus.ds_ready) begin
            win_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.shift_en   = accept;
    assign bus.shift_data = bus.in_data;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;

endmodule

// File: tb/tb_conv_slide_ctrl.sv
// Randomized scoreboard bench for conv_slide_ctrl.
// Honours CONV_SLIDE_STRIDE2_EN for the expected window set.
module tb_conv_slide_ctrl;

    localparam int DW   = 6;
    localparam int K    = 3;
    localparam int LEN  = 9;
    localparam int ROWS = 9;
`ifdef CONV_SLIDE_STRIDE2_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    conv_slide_ctrl_if #(.DATA_WIDTH(DW), .LEN(LEN), .ROWS(ROWS)) bus ();

    conv_slide_ctrl #(
        .DATA_WIDTH (DW),
        .K          (K),
        .LEN        (LEN),
        .ROWS       (ROWS)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int exp_q[$];
    int exp_cnt;
    int n_win, n_shift, n_done, acc;
    int last_r, last_c;

    logic pend_q, pend_nq, prev_stall;
    int   pend_r, pend_c, prev_r, prev_c;

    int pv = 100;
    int pd = 100;
    bit stall_first;
    bit stalled;
    int stall_left;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: latency model, hold model and in-order scoreboard.
    always @(negedge clk) begin
        if (!rstn) begin
            pend_q     = 1'b0;
            pend_nq    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (bus.start && !bus.busy) begin
                acc     = 0;
                n_win   = 0;
                n_shift = 0;
                n_done  = 0;
                last_r  = -1;
                last_c  = -1;
            end
            if (pend_q) begin
                chk("lat_valid", bus.win_valid, 1);
                chk("lat_row", bus.win_row, pend_r);
                chk("lat_col", bus.win_col, pend_c);
            end else if (pend_nq) begin
                chk("no_window", bus.win_valid, 0);
            end
            if (prev_stall) begin
                chk("hold_valid", bus.win_valid, 1);
                chk("hold_row", bus.win_row, prev_r);
                chk("hold_col", bus.win_col, prev_c);
            end
            chk("shift_en", bus.shift_en, bus.in_valid && bus.in_ready);
            if (bus.win_valid && !bus.ds_ready)
                chk("stall_ready", bus.in_ready, 0);
            if (bus.win_valid && bus.ds_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_window", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("sb_row", bus.win_row, e / 256);
                    chk("sb_col", bus.win_col, e % 256);
                end
                last_r = int'(bus.win_row);
                last_c = int'(bus.win_col);
                n_win++;
            end
            pend_q  = 1'b0;
            pend_nq = 1'b0;
            if (bus.shift_en) begin
                int r, c;
                chk("shift_data", bus.shift_data, bus.in_data);
                r = acc / LEN;
                c = acc % LEN;
                if (r >= K - 1 && c >= K - 1 &&
                    (r - K + 1) % S == 0 && (c - K + 1) % S == 0) begin
                    pend_q = 1'b1;
                    pend_r = r - K + 1;
                    pend_c = c - K + 1;
                end else begin
                    pend_nq = 1'b1;
                end
                acc++;
                n_shift++;
            end
            prev_stall = bus.win_valid && !bus.ds_ready;
            prev_r     = int'(bus.win_row);
            prev_c     = int'(bus.win_col);
            if (bus.done) n_done++;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        bus.in_valid = ($urandom % 100) < pv;
        bus.ds_ready = ($urandom % 100) < pd;
        bus.in_data  = DW'($urandom);
        if (stall_left > 0) begin
            bus.ds_ready = 1'b0;
            stall_left--;
        end else if (stall_first && !stalled && bus.win_valid) begin
            stalled      = 1'b1;
            stall_left   = 4;
            bus.ds_ready = 1'b0;
            chk("stall_first_row", bus.win_row, 0);
            chk("stall_first_col", bus.win_col, 0);
        end
        if (stall_left > 0 || (stalled && !bus.ds_ready && stall_first)) begin
            #1;
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_shift_en", bus.shift_en, 0);
        end
    endtask

    task automatic build_expected();
        exp_q.delete();
        exp_cnt = 0;
        for (int wr = 0; wr <= ROWS - K; wr += S)
            for (int wc = 0; wc <= LEN - K; wc += S) begin
                exp_q.push_back(wr * 256 + wc);
                exp_cnt++;
            end
    endtask

    task automatic issue_start();
        cycle();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic run_frame(input bit mid_start);
        bit got;
        bit sent;
        got  = 1'b0;
        sent = 1'b0;
        build_expected();
        issue_start();
        for (int i = 0; i < 4000; i++) begin
            cycle();
            bus.start = 1'b0;
            if (mid_start && !sent && n_shift >= 10) begin
                bus.start = 1'b1;
                sent      = 1'b1;
            end
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        chk("frame_done_seen", got, 1);
        chk("busy_in_done", bus.busy, 1);
        cycle();
        chk("busy_after_done", bus.busy, 0);
        chk("done_after", bus.done, 0);
        @(negedge clk);
        #1;
        chk("win_count", n_win, exp_cnt);
        chk("shift_count", n_shift, LEN * ROWS);
        chk("done_pulses", n_done, 1);
        chk("queue_empty", exp_q.size(), 0);
        chk("last_row", last_r, ((ROWS - K) / S) * S);
        chk("last_col", last_c, ((LEN - K) / S) * S);
    endtask

    task automatic reset_state_check(input string tag);
        chk({tag, "_win_valid"}, bus.win_valid, 0);
        chk({tag, "_win_row"}, bus.win_row, 0);
        chk({tag, "_win_col"}, bus.win_col, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_shift_en"}, bus.shift_en, 0);
    endtask

    task automatic reset_mid_frame();
        bit hit;
        hit = 1'b0;
        build_expected();
        issue_start();
        for (int i = 0; i < 2000; i++) begin
            cycle();
            if (n_shift >= 40) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_40_accepts", hit, 1);
        bus.in_valid = 1'b1;
        rstn = 1'b0;
        #1;
        reset_state_check("midrst");
        bus.in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rstn         = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.ds_ready = 1'b0;
        stall_first  = 1'b0;
        stalled      = 1'b0;
        stall_left   = 0;
        #2;
        reset_state_check("rst");
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        pv = 100; pd = 100;
        run_frame(1'b0);

        stall_first = 1'b1;
        run_frame(1'b0);
        stall_first = 1'b0;

        pv = 50; pd = 60;
        run_frame(1'b1);

        pv = 70; pd = 70;
        reset_mid_frame();
        run_frame(1'b0);

        pv = 30; pd = 50;
        run_frame(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
